spi_reg_bank: RTL and testbench
===============================

# spi_reg_bank

Byte-level command interpreter and register file behind the SPI slave. It consumes the bytes the slave receives and decodes them as read or write commands against eight 8-bit registers. For reads, it returns the addressed register contents to the slave's transmit-load path. All logic runs on sys_clk; frame and byte strobes arrive already in that domain.

## Interface
Parameters:
- ID_VALUE, 8'hA5, constant returned by register 7

Ports:
- sys_clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- frame_active  in  1  high while SPI slave select is asserted (one frame)
- rx_valid  in  1  one-cycle pulse: rx_data holds a complete received byte
- rx_data  in  8  received byte
- status_in  in  8  live status word, read-only at address 6
- clr_err  in  1  one-cycle pulse, clears err
- tx_data  out  8  byte to load into the slave shift register
- tx_load  out  1  one-cycle pulse: tx_data valid, slave must latch it
- ctrl_out  out  8  contents of register 0
- wr_strobe  out  1  one-cycle pulse per accepted register write
- wr_addr  out  3  address of the accepted write
- wr_data  out  8  data of the accepted write
- err  out  1  sticky protocol-error flag

## Operation
- Register map:
  - 0–5: read/write, reset to 8'h00.
  - 6: status_in, read-only.
  - 7: ID_VALUE, read-only.
- Command byte, the first byte of a frame:
  - bit7: 1 = write, 0 = read.
  - bit6: auto-increment enable.
  - bits5:3: must be 000.
  - bits2:0: start address.
- States are IDLE, CMD, WRITE, READ and DISCARD. A frame_active low level forces IDLE from any state on the next edge.
- IDLE:
  - Goes to CMD on the first cycle frame_active is high.
  - rx_valid is ignored.
- CMD, on rx_valid:
  - If bits5:3 are non-zero: set err and go to DISCARD.
  - Otherwise load the address pointer with bits2:0 and latch the auto-increment bit.
  - Write command: go to WRITE.
  - Read command: drive tx_data = reg[ptr], pulse tx_load, go to READ.
- WRITE, on each rx_valid:
  - Address 0–5: store the byte, pulse wr_strobe with wr_addr = ptr and wr_data = byte.
  - Address 6–7: discard the byte, set err, no wr_strobe.
  - Then, if auto-increment is set, ptr = ptr + 1, wrapping 7→0.
- READ, on each rx_valid (the dummy byte):
  - If auto-increment is set, ptr advances first.
  - Then tx_data = reg[ptr_new] and tx_load pulses.
  - Without auto-increment, the same register is re-sent.
- DISCARD: all bytes are ignored until the frame ends.
- err:
  - Set by a bad command or a read-only write.
  - Cleared by clr_err.
  - Set wins over a simultaneous clr_err.
- Address 6 is sampled from status_in in the same cycle tx_data is registered.

## Timing
- Reset values:
  - state IDLE, ptr 0, registers 0–5 = 00.
  - tx_data 00, tx_load 0, ctrl_out 00.
  - wr_strobe 0, wr_addr 0, wr_data 00, err 0.
- Latency for rx_valid sampled at edge N:
  - tx_load, tx_data, wr_strobe, wr_addr, wr_data and the register update (including ctrl_out) are visible after edge N, i.e. cycle N+1.
  - All strobes are exactly one cycle wide.
- rx_valid in the same cycle as the frame_active rise: the state is still IDLE, so the byte is dropped.
- rx_valid in the same cycle as frame_active low: the byte is dropped and the state goes to IDLE.
- A new frame always restarts at CMD; the pointer and auto-increment from the previous frame are not retained.
- Back-to-back rx_valid on consecutive cycles must be handled without loss.
- rst mid-frame: all outputs take their reset values immediately, and register contents are lost.

## Test plan
- Write 0x00:
  - Stimulus: frame with bytes 0xC0, 0x11, 0x22.
  - Required: wr_strobe at addr 0 data 11, then addr 1 data 22. ctrl_out = 0x11, err = 0.
- Read with auto-increment:
  - Stimulus: after the write above, frame with 0x40, 0xFF, 0xFF.
  - Required: three tx_load pulses with tx_data 0x11, 0x22, 0x00.
- Read ID and wrap:
  - Stimulus: frame with 0x47, 0xFF; status_in = 0x3C.
  - Required: tx_data 0xA5, then wrap to address 0 giving 0x11.
  - Separately, frame with 0x06: tx_data = 0x3C.
- Errors:
  - Frame with 0x98: err = 1, following bytes produce no wr_strobe.
  - Frame with 0x87, 0x55: err = 1, reg 7 unchanged.
  - clr_err pulse: err = 0.
- Boundaries:
  - rx_valid coincident with the frame_active rise: ignored.
  - Non-incrementing write 0x82, 0x01, 0x02: reg 2 = 0x02.
  - rst asserted mid-write frame: all outputs return to reset values and ctrl_out = 0x00.

Source files
------------

// File: rtl/spi_reg_bank.sv
// Command interpreter and 8-entry register file behind the SPI slave.
// Decodes framed command bytes into register writes and transmit-load reads.
module spi_reg_bank #(
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       frame_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic [7:0] status_in,
    input  logic       clr_err,
    output logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] ctrl_out,
    output logic       wr_strobe,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WRITE   = 3'd2,
        READ    = 3'd3,
        DISCARD = 3'd4
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic       ainc;
    logic [7:0] regs [0:5];

    logic [2:0] rd_addr;
    logic [7:0] rd_val;
    logic       bad_cmd;
    logic       ro_write;
    logic       err_set;

    assign ctrl_out = regs[0];

    // A read command reads its own start address; a dummy byte in READ reads
    // the post-increment address, so the lookup uses the advanced pointer.
    always_comb begin
        rd_addr = ptr;
        if (state == CMD) begin
            rd_addr = rx_data[2:0];
        end else if (ainc) begin
            rd_addr = ptr + 3'd1;
        end
    end

    always_comb begin
        rd_val = 8'h00;
        case (rd_addr)
            3'd0:    rd_val = regs[0];
            3'd1:    rd_val = regs[1];
            3'd2:    rd_val = regs[2];
            3'd3:    rd_val = regs[3];
            3'd4:    rd_val = regs[4];
            3'd5:    rd_val = regs[5];
            3'd6:    rd_val = status_in;
            default: rd_val = ID_VALUE;
        endcase
    end

    always_comb begin
        bad_cmd  = frame_active && rx_valid && (state == CMD) && (rx_data[5:3] != 3'b000);
        ro_write = frame_active && rx_valid && (state == WRITE) && (ptr >= 3'd6);
        err_set  = bad_cmd || ro_write;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            ainc      <= 1'b0;
            tx_data   <= 8'h00;
            tx_load   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 3'd0;
            wr_data   <= 8'h00;
            err       <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            tx_load   <= 1'b0;
            wr_strobe <= 1'b0;

            if (err_set) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end

            if (!frame_active) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: state <= CMD;
                    CMD: begin
                        if (rx_valid) begin
                            if (bad_cmd) begin
                                state <= DISCARD;
                            end else begin
                                ptr  <= rx_data[2:0];
                                ainc <= rx_data[6];
                                if (rx_data[7]) begin
                                    state <= WRITE;
                                end else begin
                                    tx_data <= rd_val;
                                    tx_load <= 1'b1;
                                    state   <= READ;
                                end
                            end
                        end
                    end
                    WRITE: begin
                        if (rx_valid) begin
                            if (!ro_write) begin
                                for (int i = 0; i < 6; i++) begin
                                    if (ptr == 3'(i)) begin
                                        regs[i] <= rx_data;
                                    end
                                end
                                wr_strobe <= 1'b1;
                                wr_addr   <= ptr;
                                wr_data   <= rx_data;
                            end
                            if (ainc) begin
                                ptr <= ptr + 3'd1;
                            end
                        end
                    end
                    READ: begin
                        if (rx_valid) begin
                            if (ainc) begin
                                ptr <= ptr + 3'd1;
                            end
                            tx_data <= rd_val;
                            tx_load <= 1'b1;
                        end
                    end
                    DISCARD: state <= DISCARD;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed frames with literal expectations plus
// random frames checked every cycle against a byte-count based model.
module tb_spi_reg_bank;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] status_in = 8'h00;
    logic       clr_err = 1'b0;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] ctrl_out;
    logic       wr_strobe;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       err;

    spi_reg_bank #(.ID_VALUE(8'hA5)) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .frame_active(frame_active),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .status_in(status_in),
        .clr_err(clr_err),
        .tx_data(tx_data),
        .tx_load(tx_load),
        .ctrl_out(ctrl_out),
        .wr_strobe(wr_strobe),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .err(err)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail = 0;
    bit started = 1'b0;
    bit rand_mode = 1'b0;

    logic [7:0]  tx_log[$];
    logic [10:0] wr_log[$];
    logic [7:0]  exp_q[$];
    logic [10:0] exp_wr[$];
    logic [7:0]  frame_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_regs[6];
    bit         in_frame, m_write, m_ainc, m_discard;
    int         ptr, nbyte;
    logic [7:0] e_tx_data, e_wr_data;
    logic [2:0] e_wr_addr;
    bit         e_tx_load, e_wr_strobe, e_err;

    function automatic logic [7:0] m_read(input int p);
        if (p < 6) return m_regs[p];
        if (p == 6) return status_in;
        return 8'hA5;
    endfunction

    always @(posedge sys_clk or posedge rst) begin : model
        bit es;
        logic [7:0] b;
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 8'h00;
            in_frame = 0; m_write = 0; m_ainc = 0; m_discard = 0;
            ptr = 0; nbyte = 0;
            e_tx_data = 8'h00; e_wr_data = 8'h00; e_wr_addr = 3'd0;
            e_tx_load = 0; e_wr_strobe = 0; e_err = 0;
        end else begin
            es = 0;
            b = rx_data;
            e_tx_load = 0;
            e_wr_strobe = 0;
            if (!frame_active) begin
                in_frame = 0;
            end else if (!in_frame) begin
                in_frame = 1;
                nbyte = 0;
            end else if (rx_valid) begin
                if (nbyte == 0) begin
                    if (b[5:3] != 3'b000) begin
                        m_discard = 1;
                        es = 1;
                    end else begin
                        m_discard = 0;
                        ptr = int'(b[2:0]);
                        m_ainc = b[6];
                        m_write = b[7];
                        if (!m_write) begin
                            e_tx_data = m_read(ptr);
                            e_tx_load = 1;
                        end
                    end
                end else if (!m_discard) begin
                    if (m_write) begin
                        if (ptr < 6) begin
                            m_regs[ptr] = b;
                            e_wr_strobe = 1;
                            e_wr_addr = 3'(ptr);
                            e_wr_data = b;
                        end else begin
                            es = 1;
                        end
                        if (m_ainc) ptr = (ptr + 1) % 8;
                    end else begin
                        if (m_ainc) ptr = (ptr + 1) % 8;
                        e_tx_data = m_read(ptr);
                        e_tx_load = 1;
                    end
                end
                nbyte++;
            end
            if (es) e_err = 1;
            else if (clr_err) e_err = 0;
        end
    end

    // ---------------- per-cycle compare + logging ----------------
    always @(negedge sys_clk) begin
        if (started) begin
            check("tx_load", tx_load, e_tx_load);
            check("wr_strobe", wr_strobe, e_wr_strobe);
            if (e_tx_load) check("tx_data", tx_data, e_tx_data);
            if (e_wr_strobe) begin
                check("wr_addr", wr_addr, e_wr_addr);
                check("wr_data", wr_data, e_wr_data);
            end
            check("ctrl_out", ctrl_out, m_regs[0]);
            check("err", err, e_err);
            if (tx_load) tx_log.push_back(tx_data);
            if (wr_strobe) wr_log.push_back({wr_addr, wr_data});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge sys_clk);
        #2;
        if (rand_mode) begin
            clr_err = ($urandom_range(0, 7) == 0);
            status_in = 8'($urandom);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        tick();
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic send_frame(input bit gaps);
        tx_log.delete();
        wr_log.delete();
        frame_active = 1'b1;
        if (rand_mode && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b1;
            rx_data = 8'($urandom);
        end
        tick();
        rx_valid = 1'b0;
        foreach (frame_q[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_byte(frame_q[i]);
        end
        tick();
        frame_active = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_tx(input string name);
        check({name, "_count"}, tx_log.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < tx_log.size()) check(name, tx_log[i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    task automatic check_wr(input string name);
        check({name, "_count"}, wr_log.size(), exp_wr.size());
        foreach (exp_wr[i]) begin
            if (i < wr_log.size()) check(name, wr_log[i], exp_wr[i]);
        end
        exp_wr.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_tx_load"}, tx_load, 1'b0);
        check({tag, "_ctrl_out"}, ctrl_out, 8'h00);
        check({tag, "_wr_strobe"}, wr_strobe, 1'b0);
        check({tag, "_wr_addr"}, wr_addr, 3'd0);
        check({tag, "_wr_data"}, wr_data, 8'h00);
        check({tag, "_err"}, err, 1'b0);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge sys_clk);
        #2;
        rst = 1'b0;
        started = 1'b1;
        check_reset_outputs("reset");

        status_in = 8'h3C;

        frame_q = '{8'hC0, 8'h11, 8'h22};
        send_frame(1'b0);
        exp_wr = '{11'h011, 11'h122};
        check_wr("write0");
        check("write0_ctrl", ctrl_out, 8'h11);
        check("write0_err", err, 1'b0);

        frame_q = '{8'h40, 8'hFF, 8'hFF};
        send_frame(1'b0);
        exp_q = '{8'h11, 8'h22, 8'h00};
        check_tx("read_ainc");

        frame_q = '{8'h47, 8'hFF};
        send_frame(1'b1);
        exp_q = '{8'hA5, 8'h11};
        check_tx("read_id_wrap");

        frame_q = '{8'h06};
        send_frame(1'b0);
        exp_q = '{8'h3C};
        check_tx("read_status");

        frame_q = '{8'h98, 8'h12, 8'h34};
        send_frame(1'b0);
        check("bad_cmd_err", err, 1'b1);
        check_wr("bad_cmd_nowrite");

        pulse_clr();
        check("clr_err", err, 1'b0);

        frame_q = '{8'h87, 8'h55};
        send_frame(1'b0);
        check("ro_write_err", err, 1'b1);
        check_wr("ro_write_nowrite");
        frame_q = '{8'h07};
        send_frame(1'b0);
        exp_q = '{8'hA5};
        check_tx("reg7_unchanged");
        pulse_clr();
        check("clr_err2", err, 1'b0);

        // A byte on the rise edge would otherwise become a 0x82 command.
        tx_log.delete();
        wr_log.delete();
        frame_active = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h82;
        tick();
        rx_valid = 1'b0;
        send_byte(8'h82);
        send_byte(8'h01);
        send_byte(8'h02);
        tick();
        frame_active = 1'b0;
        tick();
        exp_wr = '{11'h201, 11'h202};
        check_wr("rise_drop_noinc");
        frame_q = '{8'h02};
        send_frame(1'b0);
        exp_q = '{8'h02};
        check_tx("reg2_readback");

        // Byte coinciding with frame end is dropped.
        wr_log.delete();
        frame_active = 1'b1;
        tick();
        send_byte(8'hC3);
        frame_active = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'h77;
        tick();
        rx_valid = 1'b0;
        tick();
        check_wr("fall_drop");
        frame_q = '{8'h03};
        send_frame(1'b0);
        exp_q = '{8'h00};
        check_tx("reg3_untouched");

        // Reset in the middle of a write frame.
        frame_active = 1'b1;
        tick();
        send_byte(8'hC0);
        send_byte(8'hAA);
        check("pre_rst_ctrl", ctrl_out, 8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe_rst");
        tick();
        frame_active = 1'b0;
        rst = 1'b0;
        tick();
        frame_q = '{8'h41, 8'hFF};
        send_frame(1'b0);
        exp_q = '{8'h00, 8'h00};
        check_tx("regs_lost_after_rst");

        // Randomized frames.
        rand_mode = 1'b1;
        repeat (200) begin
            frame_q.delete();
            if ($urandom_range(0, 7) == 0) begin
                frame_q.push_back(8'($urandom));
            end else begin
                frame_q.push_back({2'($urandom), 3'b000, 3'($urandom)});
            end
            repeat ($urandom_range(0, 6)) frame_q.push_back(8'($urandom));
            if ($urandom_range(0, 14) == 0) begin
                frame_active = 1'b1;
                tick();
                send_byte(frame_q[0]);
                send_byte(8'($urandom));
                rst = 1'b1;
                tick();
                rst = 1'b0;
                frame_active = 1'b0;
                tick();
            end else begin
                send_frame(1'b1);
            end
        end
        rand_mode = 1'b0;
        clr_err = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
